keypad_matrix_emulator: RTL

- Responder end of the 4x4 keypad scan interface. The keypad scanner drives rows (`line`) and reads columns. This block answers that scan as a physical key matrix would.
- It accepts "press key N for H cycles" requests and drives `column` according to the currently scanned row.
- Optionally it adds contact bounce.
- Uses: simulation bench partner for the scanner, and scripted on-chip key injection (stopwatch/calculator self-test).

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_bounce_gen.sv | 31 +++
 rtl/keypad_matrix_emulator.sv | 129 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, function-key codes and key-code field helpers
// for the keypad matrix emulator.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } kp_state_e;

    localparam logic [3:0] KEY_RESET     = 4'd10;
    localparam logic [3:0] KEY_RUN       = 4'd11;
    localparam logic [3:0] KEY_PAUSE     = 4'd12;
    localparam logic [3:0] KEY_MODE_BACK = 4'd13;
    localparam logic [3:0] KEY_OP_A      = 4'd14;
    localparam logic [3:0] KEY_OP_B      = 4'd15;

    function automatic logic [1:0] code_row(input logic [3:0] code);
        return code[3:2];
    endfunction

    function automatic logic [1:0] code_col(input logic [3:0] code);
        return code[1:0];
    endfunction

endpackage

// File: rtl/keypad_bounce_gen.sv
// keypad_bounce_gen: bounce phase counter; reports the contact level for the
// counter value being loaded this cycle, closed-first or open-first.
module keypad_bounce_gen #(
    parameter int BOUNCE_CYCLES = 6,
    parameter int BOUNCE_PERIOD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    input  logic open_first,
    output logic last,
    output logic bounce_contact
);

    logic [15:0] bcnt_q, bcnt_d, phase;

    always_comb begin
        bcnt_d = start ? 16'd0 : run ? bcnt_q + 16'd1 : bcnt_q;
        phase = bcnt_d / 16'(BOUNCE_PERIOD);
        bounce_contact = open_first ? phase[0] : ~phase[0];
    end

    assign last = bcnt_q == 16'(BOUNCE_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcnt_q <= '0;
        else        bcnt_q <= bcnt_d;
    end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: answers a 4x4 row scan as a pressed key would.
// Contact bounce phases exist only when KEYPAD_MATRIX_EMULATOR_BOUNCE_EN is defined.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 6,
    parameter int BOUNCE_PERIOD = 2,
    parameter int GAP_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  line,
    output logic [3:0]  column,
    input  logic        press_valid,
    output logic        press_ready,
    input  logic [3:0]  press_code,
    input  logic [15:0] press_hold,
    output logic        contact,
    output logic        busy,
    output logic        done
);

    kp_state_e   state_q, state_d;
    logic [1:0]  row_q, row_d, col_q, col_d;
    logic [15:0] hold_q, hold_d, hcnt_q, hcnt_d, gcnt_q, gcnt_d;
    logic        contact_q, contact_d, done_q, done_d;
    logic [3:0]  column_q, column_d;
    logic        accept, hold_end, gap_end, bnc_last, bnc_contact;

    assign accept   = press_valid & press_ready;
    assign hold_end = hcnt_q == (hold_q == 16'd0 ? 16'd1 : hold_q) - 16'd1;
    assign gap_end  = gcnt_q == 16'(GAP_CYCLES - 1);

`ifdef KEYPAD_MATRIX_EMULATOR_BOUNCE_EN
    localparam kp_state_e AFTER_IDLE = BOUNCE_IN;
    localparam kp_state_e AFTER_HOLD = BOUNCE_OUT;

    keypad_bounce_gen #(
        .BOUNCE_CYCLES(BOUNCE_CYCLES),
        .BOUNCE_PERIOD(BOUNCE_PERIOD)
    ) u_bounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         ((state_q == IDLE && accept) || (state_q == HOLD && hold_end)),
        .run           (state_q inside {BOUNCE_IN, BOUNCE_OUT}),
        .open_first    (state_d == BOUNCE_OUT),
        .last          (bnc_last),
        .bounce_contact(bnc_contact)
    );
`else
    localparam kp_state_e AFTER_IDLE = HOLD;
    localparam kp_state_e AFTER_HOLD = GAP;
    logic unused_bounce;
    assign unused_bounce = ^{BOUNCE_CYCLES, BOUNCE_PERIOD};
    assign bnc_last    = 1'b0;
    assign bnc_contact = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        hold_d  = hold_q;
        hcnt_d  = hcnt_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = AFTER_IDLE;
                row_d   = code_row(press_code);
                col_d   = code_col(press_code);
                hold_d  = press_hold;
                hcnt_d  = '0;
            end
            BOUNCE_IN: if (bnc_last) begin
                state_d = HOLD;
                hcnt_d  = '0;
            end
            HOLD: if (hold_end) begin
                state_d = AFTER_HOLD;
                gcnt_d  = '0;
            end else hcnt_d = hcnt_q + 16'd1;
            BOUNCE_OUT: if (bnc_last) begin
                state_d = GAP;
                gcnt_d  = '0;
            end
            GAP: if (gap_end) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else gcnt_d = gcnt_q + 16'd1;
            default: state_d = IDLE;
        endcase
        // contact is registered from next-state values so it lines up with state_q
        contact_d = (state_d == HOLD) || ((state_d inside {BOUNCE_IN, BOUNCE_OUT}) && bnc_contact);
        column_d = 4'b1111;
        column_d[col_q] = ~(contact_q & ~line[row_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            hold_q    <= '0;
            hcnt_q    <= '0;
            gcnt_q    <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            column_q  <= 4'b1111;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            hold_q    <= hold_d;
            hcnt_q    <= hcnt_d;
            gcnt_q    <= gcnt_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            column_q  <= column_d;
        end
    end

    assign column      = column_q;
    assign contact     = contact_q;
    assign done        = done_q;
    assign busy        = state_q != IDLE;
    assign press_ready = (state_q == IDLE) & ~done_q;

endmodule
